// File: rtl/ps2_keyboard_controller.sv
// ps2_keyboard_controller: sequences the ps2_protocol link. Resets the keyboard
// (0xFF, ACK 0xFA, BAT 0xAA), forwards scan codes to the host and serialises LED
// updates as 0xED + data. Optional macro PS2_RETRY_EN enables per-byte resends.
module ps2_keyboard_controller #(
  parameter int TIMEOUT_CYCLES = 51_800_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       ack_ready,
  input  logic       ack_valid,
  input  logic       ack_error,
  output logic       rx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_byte,
  output logic       leds_ready,
  input  logic       leds_valid,
  input  logic [2:0] leds,
  output logic       init_done,
  output logic       init_error,
  output logic       led_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_INIT_SEND, S_INIT_ACK, S_INIT_RESP, S_INIT_BAT,
    S_IDLE,
    S_LED_CMD_SEND, S_LED_CMD_ACK, S_LED_CMD_RESP,
    S_LED_DAT_SEND, S_LED_DAT_ACK, S_LED_DAT_RESP,
    S_FAIL
  } state_t;

  state_t         state, state_nxt, resend_st;
  logic [TW-1:0]  tmr;
  logic           timeout;
  logic [2:0]     led_q;
  logic           in_resp, is_send, init_grp;
  logic [7:0]     send_byte;
  logic           fail_retry, fail_hard;
  logic           led_err_set, init_err_set, init_done_set;

`ifdef PS2_RETRY_EN
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  logic [RW-1:0]  retry_cnt;
  logic           retry_taken;
`endif

  // Every ack is owned by this block; stray acks are simply swallowed.
  assign ack_ready  = 1'b1;
  assign leds_ready = (state == S_IDLE);
  // Response/BAT bytes belong to the controller; otherwise single-entry key register.
  assign rx_ready   = in_resp ? 1'b1 : !key_valid;
  assign timeout    = (tmr == TW'(TIMEOUT_CYCLES - 1));

  // State classification, byte to send and the SEND state a retry returns to.
  always_comb begin
    in_resp  = state inside {S_INIT_RESP, S_INIT_BAT, S_LED_CMD_RESP, S_LED_DAT_RESP};
    is_send  = state inside {S_INIT_SEND, S_LED_CMD_SEND, S_LED_DAT_SEND};
    init_grp = state inside {S_INIT_SEND, S_INIT_ACK, S_INIT_RESP, S_INIT_BAT};
    if (init_grp) begin
      send_byte = 8'hFF;
      resend_st = S_INIT_SEND;
    end else if (state inside {S_LED_CMD_SEND, S_LED_CMD_ACK, S_LED_CMD_RESP}) begin
      send_byte = 8'hED;
      resend_st = S_LED_CMD_SEND;
    end else begin
      send_byte = {5'b0, led_q};
      resend_st = S_LED_DAT_SEND;
    end
  end

  // Next-state logic: advance on handshakes, then fold failures into retry or abort.
  always_comb begin
    state_nxt     = state;
    fail_retry    = 1'b0;
    fail_hard     = 1'b0;
    led_err_set   = 1'b0;
    init_err_set  = 1'b0;
    init_done_set = 1'b0;
`ifdef PS2_RETRY_EN
    retry_taken   = 1'b0;
`endif
    case (state)
      S_INIT_SEND:    if (cmd_valid && cmd_ready) state_nxt = S_INIT_ACK;
      S_LED_CMD_SEND: if (cmd_valid && cmd_ready) state_nxt = S_LED_CMD_ACK;
      S_LED_DAT_SEND: if (cmd_valid && cmd_ready) state_nxt = S_LED_DAT_ACK;
      S_INIT_ACK, S_LED_CMD_ACK, S_LED_DAT_ACK: begin
        if (ack_valid) begin
          if (ack_error)                     fail_retry = 1'b1;
          else if (state == S_INIT_ACK)      state_nxt  = S_INIT_RESP;
          else if (state == S_LED_CMD_ACK)   state_nxt  = S_LED_CMD_RESP;
          else                               state_nxt  = S_LED_DAT_RESP;
        end
      end
      S_INIT_RESP, S_LED_CMD_RESP, S_LED_DAT_RESP: begin
        // A byte arriving with the timeout takes priority; unknown bytes are ignored.
        if (rx_valid) begin
          if (rx_byte == 8'hFA) begin
            if (state == S_INIT_RESP)         state_nxt = S_INIT_BAT;
            else if (state == S_LED_CMD_RESP) state_nxt = S_LED_DAT_SEND;
            else                              state_nxt = S_IDLE;
          end else if (rx_byte == 8'hFE) begin
            fail_retry = 1'b1;
          end
        end else if (timeout) begin
          fail_retry = 1'b1;
        end
      end
      S_INIT_BAT: begin
        if (rx_valid) begin
          if (rx_byte == 8'hAA) begin
            state_nxt     = S_IDLE;
            init_done_set = 1'b1;
          end else if (rx_byte == 8'hFC) begin
            fail_hard = 1'b1;
          end else begin
            fail_retry = 1'b1;
          end
        end else if (timeout) begin
          fail_retry = 1'b1;
        end
      end
      S_IDLE: if (leds_valid) state_nxt = S_LED_CMD_SEND;
      default: state_nxt = S_FAIL;
    endcase
    if (fail_retry || fail_hard) begin
`ifdef PS2_RETRY_EN
      if (fail_retry && (retry_cnt < RW'(MAX_RETRIES))) begin
        state_nxt   = resend_st;
        retry_taken = 1'b1;
      end else
`endif
      if (init_grp) begin
        state_nxt    = S_FAIL;
        init_err_set = 1'b1;
      end else begin
        state_nxt   = S_IDLE;
        led_err_set = 1'b1;
      end
    end
  end

  // State register, command channel, status flags and latched LED value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT_SEND;
      cmd_valid  <= 1'b0;
      cmd_byte   <= 8'h00;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      led_error  <= 1'b0;
      led_q      <= 3'b000;
    end else begin
      state     <= state_nxt;
      led_error <= led_err_set;
      if (init_done_set) init_done  <= 1'b1;
      if (init_err_set)  init_error <= 1'b1;
      if (state == S_IDLE && leds_valid) led_q <= leds;
      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end else if (is_send) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= send_byte;
      end
    end
  end

  // Host scan-code register; nothing is forwarded until the keyboard is initialised.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_byte  <= 8'h00;
    end else begin
      if (key_valid && key_ready) key_valid <= 1'b0;
      if (rx_valid && rx_ready && !in_resp && init_done) begin
        key_valid <= 1'b1;
        key_byte  <= rx_byte;
      end
    end
  end

  // Response timer, restarted on every state change and saturating at expiry.
  always_ff @(posedge clk) begin
    if (reset)                   tmr <= '0;
    else if (state_nxt != state) tmr <= '0;
    else if (!timeout)           tmr <= tmr + 1'b1;
  end

`ifdef PS2_RETRY_EN
  // Per-byte resend counter; cleared once a byte completes or a sequence ends.
  always_ff @(posedge clk) begin
    if (reset)            retry_cnt <= '0;
    else if (retry_taken) retry_cnt <= retry_cnt + 1'b1;
    else if (state_nxt != state && (in_resp || state_nxt == S_IDLE || state_nxt == S_FAIL))
      retry_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_ps2_keyboard_controller.sv
// Directed bench for ps2_keyboard_controller with a keyboard/protocol model and
// scoreboard queues for issued command bytes and forwarded scan codes.
module tb_ps2_keyboard_controller;
  localparam int TO = 100;

  logic       clk = 1'b0, reset = 1'b1;
  logic       cmd_ready = 1'b0, ack_valid = 1'b0, ack_error = 1'b0;
  logic       rx_valid = 1'b0, key_ready = 1'b0, leds_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [2:0] leds = 3'b000;
  logic       cmd_valid, ack_ready, rx_ready, key_valid, leds_ready;
  logic       init_done, init_error, led_error;
  logic [7:0] cmd_byte, key_byte;

  int n_cmp = 0, n_err = 0, led_pulses = 0, p0 = 0;
  logic [7:0] cmd_q[$];
  logic [7:0] key_q[$];

  ps2_keyboard_controller #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .ack_ready(ack_ready), .ack_valid(ack_valid), .ack_error(ack_error),
    .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .key_ready(key_ready), .key_valid(key_valid), .key_byte(key_byte),
    .leds_ready(leds_ready), .leds_valid(leds_valid), .leds(leds),
    .init_done(init_done), .init_error(init_error), .led_error(led_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && led_error) led_pulses++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for a command, compare against the scoreboard, then complete the transfer.
  task automatic do_cmd(input string tag);
    int n = 0;
    logic [7:0] e;
    while (!cmd_valid && n < 300) begin tick(); n++; end
    check({tag, "_valid"}, cmd_valid, 1);
    e = (cmd_q.size() > 0) ? cmd_q.pop_front() : 8'hxx;
    check(tag, cmd_byte, e);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    check({tag, "_drop"}, cmd_valid, 0);
  endtask

  task automatic send_ack(input logic err);
    ack_valid = 1'b1; ack_error = err; tick();
    ack_valid = 1'b0; ack_error = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1; rx_byte = b;
    while (!rx_ready && n < 300) begin tick(); n++; end
    tick(); rx_valid = 1'b0;
  endtask

  task automatic pop_key(input string tag);
    int n = 0;
    logic [7:0] e;
    while (!key_valid && n < 300) begin tick(); n++; end
    check({tag, "_valid"}, key_valid, 1);
    e = (key_q.size() > 0) ? key_q.pop_front() : 8'hxx;
    check(tag, key_byte, e);
    key_ready = 1'b1; tick(); key_ready = 1'b0;
  endtask

  task automatic led_req(input logic [2:0] v);
    leds_valid = 1'b1; leds = v; tick(); leds_valid = 1'b0;
    cmd_q.push_back(8'hED);
  endtask

  task automatic do_init();
    cmd_q.push_back(8'hFF);
    do_cmd("init_ff");
    send_ack(1'b0);
    send_rx(8'hFA);
    send_rx(8'hAA);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_byte", cmd_byte, 8'h00);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_byte", key_byte, 8'h00);
    check("rst_leds_ready", leds_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_error", init_error, 0);
    check("rst_led_error", led_error, 0);
    check("rst_ack_ready", ack_ready, 1);
    reset = 1'b0; tick();
    check("cmd_rise", cmd_valid, 1);

    // A byte before init completes is dropped, then the happy-path init
    send_rx(8'h55);
    check("preinit_drop", key_valid, 0);
    do_init();
    check("init_done", init_done, 1);
    check("init_err0", init_error, 0);
    check("init_no_key", key_valid, 0);
    check("idle_leds_ready", leds_ready, 1);
    repeat (5) tick();
    check("single_ff", cmd_valid, 0);

    // Scan-code backpressure
    key_q.push_back(8'h1C);
    send_rx(8'h1C);
    check("bp_key_valid", key_valid, 1);
    check("bp_key_byte", key_byte, 8'h1C);
    rx_valid = 1'b1; rx_byte = 8'hF0;
    repeat (3) tick();
    check("bp_hold", key_byte, 8'h1C);
    check("bp_rx_ready", rx_ready, 0);
    key_q.push_back(8'hF0);
    pop_key("bp_first");
    tick(); rx_valid = 1'b0;
    pop_key("bp_second");

    // LED update 3'b101, with a second request held pending until idle
    p0 = led_pulses;
    led_req(3'b101);
    check("led_busy", leds_ready, 0);
    leds_valid = 1'b1; leds = 3'b010;
    do_cmd("led_ed"); send_ack(1'b0); send_rx(8'hFA);
    cmd_q.push_back(8'h05);
    do_cmd("led_05"); send_ack(1'b0); send_rx(8'hFA);
    check("led_back_idle", leds_ready, 1);
    tick(); leds_valid = 1'b0;
    cmd_q.push_back(8'hED);
    do_cmd("led2_ed"); send_ack(1'b0); send_rx(8'hFA);
    cmd_q.push_back(8'h02);
    do_cmd("led2_02"); send_ack(1'b0); send_rx(8'hFA);
    tick();
    check("led_no_err", led_pulses - p0, 0);

    // Resend on 0xFE
    p0 = led_pulses;
    led_req(3'b001);
    do_cmd("fe_ed"); send_ack(1'b0); send_rx(8'hFE);
`ifdef PS2_RETRY_EN
    check("fe_no_err", led_error, 0);
    cmd_q.push_back(8'hED);
    do_cmd("fe_resend"); send_ack(1'b0); send_rx(8'hFA);
    cmd_q.push_back(8'h01);
    do_cmd("fe_01"); send_ack(1'b0); send_rx(8'hFA);
    tick();
    check("fe_pulses", led_pulses - p0, 0);
`else
    check("fe_led_error", led_error, 1);
    check("fe_idle", leds_ready, 1);
    tick();
    check("fe_pulse_once", led_pulses - p0, 1);
`endif

    // Response timeout: failure exactly TO cycles after entering RESP
    p0 = led_pulses;
    led_req(3'b100);
    do_cmd("to_ed"); send_ack(1'b0);
`ifdef PS2_RETRY_EN
    for (int r = 0; r < 4; r++) begin
      repeat (TO - 1) tick();
      check("to_early", led_error, 0);
      tick();
      if (r < 3) begin
        check("to_retry_no_err", led_error, 0);
        cmd_q.push_back(8'hED);
        do_cmd("to_resend"); send_ack(1'b0);
      end else begin
        check("to_led_error", led_error, 1);
      end
    end
`else
    repeat (TO - 1) tick();
    check("to_early", led_error, 0);
    tick();
    check("to_led_error", led_error, 1);
`endif
    check("to_idle", leds_ready, 1);
    tick();
    check("to_pulse_once", led_pulses - p0, 1);
    check("to_one_cycle", led_error, 0);

    // Reset mid-sequence while a command is pending
    led_req(3'b011);
    while (!cmd_valid) tick();
    reset = 1'b1; tick();
    cmd_q.delete();
    check("mid_cmd_valid", cmd_valid, 0);
    check("mid_cmd_byte", cmd_byte, 8'h00);
    check("mid_init_done", init_done, 0);
    check("mid_leds_ready", leds_ready, 0);
    check("mid_ack_ready", ack_ready, 1);
    reset = 1'b0; tick();
    do_init();
    check("mid_reinit", init_done, 1);

    // Init BAT failure
    reset = 1'b1; tick(); reset = 1'b0;
    cmd_q.push_back(8'hFF);
    do_cmd("bat_ff"); send_ack(1'b0); send_rx(8'hFA); send_rx(8'hFC);
    check("bat_init_error", init_error, 1);
    check("bat_init_done", init_done, 0);
    check("bat_leds_ready", leds_ready, 0);
    send_rx(8'h33);
    leds_valid = 1'b1;
    repeat (3) tick();
    check("fail_no_key", key_valid, 0);
    check("fail_leds_ready", leds_ready, 0);
    check("fail_no_cmd", cmd_valid, 0);
    leds_valid = 1'b0;

    check("cmd_q_empty", cmd_q.size(), 0);
    check("key_q_empty", key_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_controller.md
# ps2_keyboard_controller

Sequences the `ps2_protocol` link on behalf of the rest of the design.
- Out of reset it runs the keyboard initialisation: reset command 0xFF, then wait for ACK 0xFA and BAT-pass 0xAA.
- It then forwards scan codes to the host side and serialises LED-update requests as the two-byte 0xED + data exchange.
- It sits between `ps2_protocol`'s command, command-ack and scan-code channels and the terminal/keyboard logic. It owns every byte the keyboard sends in response to a command.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 51_800_000: cycles allowed for each keyboard response byte (1 s at 51.8 MHz; covers BAT).
- `MAX_RETRIES`, default 3: resend attempts per command byte; used only with `PS2_RETRY_EN`.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high. Aborts any sequence; init restarts on release.
- `cmd_ready` in 1: from `ps2_protocol` `command_ready`.
- `cmd_valid` out 1: to `command_valid`.
- `cmd_byte` out 8: to `command_byte`.
- `ack_ready` out 1: to `command_ack_ready`.
- `ack_valid` in 1: from `command_ack_valid`.
- `ack_error` in 1: from `command_ack_error`.
- `rx_ready` out 1: to `scan_code_ready`.
- `rx_valid` in 1: from `scan_code_valid`.
- `rx_byte` in 8: from `scan_code_byte`.
- `key_ready` in 1: host accepts a scan code.
- `key_valid` out 1: scan code available.
- `key_byte` out 8: scan code.
- `leds_ready` out 1: LED request accepted.
- `leds_valid` in 1: LED request.
- `leds` in 3: [0] scroll, [1] num, [2] caps.
- `init_done` out 1: keyboard initialised; sticky until reset.
- `init_error` out 1: initialisation failed; sticky until reset.
- `led_error` out 1: one-cycle pulse when an LED update fails.

## Operation
- Reset values: `cmd_valid`, `key_valid`, `leds_ready`, `init_done`, `init_error`, `led_error` = 0; `cmd_byte`, `key_byte` = 0x00; `ack_ready` = 1; state = S_INIT_SEND.
- Command issue (shared by all sequences):
  - SEND state drives `cmd_valid` = 1 with `cmd_byte` stable.
  - Transfer occurs on a cycle with `cmd_valid && cmd_ready`; the next state is ACK.
  - ACK state waits for `ack_valid`. `ack_error` = 0 -> RESP state; `ack_error` = 1 -> failure.
  - RESP state waits for an `rx_valid` byte, with the timeout counter running. 0xFA -> success; 0xFE -> failure; timeout -> failure.
- States and transitions:
  - Init: S_INIT_SEND (0xFF) -> S_INIT_ACK -> S_INIT_RESP (expect 0xFA) -> S_INIT_BAT.
  - S_INIT_BAT: 0xAA -> `init_done` = 1, go S_IDLE. 0xFC, other byte or timeout -> failure.
  - S_IDLE: `leds_ready` = 1. `leds_valid && leds_ready` latches `leds` -> S_LED_CMD_SEND.
  - LED command: S_LED_CMD_SEND (0xED) -> S_LED_CMD_ACK -> S_LED_CMD_RESP.
  - LED data: S_LED_DAT_SEND ({5'b0, leds}) -> S_LED_DAT_ACK -> S_LED_DAT_RESP -> S_IDLE.
  - S_FAIL: terminal; only `reset` leaves it.
- Failure without retry:
  - In init states: go S_FAIL, `init_error` = 1.
  - In LED states: `led_error` pulses one cycle, return to S_IDLE.
- Scan-code routing:
  - In RESP and BAT states the controller consumes `rx_byte` itself: `rx_ready` = 1, and the byte is never forwarded.
  - In all other states, `rx_ready` = !`key_valid` (single-entry output register).
  - Accepted byte loads `key_byte`, sets `key_valid`. `key_valid && key_ready` clears it.
  - Scan codes are forwarded only once `init_done` = 1. Before that, bytes outside RESP/BAT states are consumed and dropped.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1); cleared on entering every RESP/BAT state.
  - Expires when the count reaches TIMEOUT_CYCLES - 1.
- Simultaneous events:
  - `rx_valid` and timeout in the same cycle: the byte wins.
  - `leds_valid` during a running LED sequence: not accepted (`leds_ready` = 0), so no request is lost.

## Timing
- `cmd_valid` rises the cycle after entering a SEND state and falls the cycle after the transfer.
- Response byte accepted -> next state the following cycle, and the next `cmd_valid` one cycle after that.
- `rx_valid`/`rx_ready` transfer -> `key_valid` = 1 the next cycle.
- `init_done` asserts the cycle after 0xAA is accepted.
- `reset` mid-sequence:
  - `cmd_valid` drops the next cycle; a byte already in flight in `ps2_protocol` completes unobserved.
  - Its ack and any responses are consumed or dropped by the restarted init sequence.

## Configuration
- `PS2_RETRY_EN` defined:
  - A failure in any ACK or RESP state (`ack_error`, 0xFE, timeout) returns to the same SEND state and resends the same byte.
  - The per-byte retry counter resets on success.
  - After MAX_RETRIES resends, the failure rules above apply.
  - 0xFC in S_INIT_BAT is never retried.
- `PS2_RETRY_EN` undefined: no retry counter is implemented; the first failure applies the failure rules.

## Test plan
- Init happy path: keyboard model ACKs the 0xFF transfer, then sends 0xFA, then 0xAA -> exactly one 0xFF issued, `init_done` = 1, `init_error` = 0, neither byte appears on `key_*`.
- Init BAT fail: model returns 0xFA then 0xFC -> S_FAIL, `init_error` = 1, `leds_ready` stays 0, later scan codes are not forwarded.
- LED update: after init, `leds_valid` with `leds` = 3'b101 -> `cmd_byte` 0xED then 0x05, each followed by 0xFA -> return to S_IDLE, no `led_error`.
- Scan-code backpressure: `key_ready` held 0, model sends 0x1C then 0xF0 -> `key_byte` = 0x1C held, `rx_ready` = 0; release `key_ready` -> 0xF0 delivered next.
- Timeout with TIMEOUT_CYCLES = 100: no response after the ack -> failure exactly 100 cycles after entering RESP.
  - Without the macro: `led_error` pulse.
  - With `PS2_RETRY_EN`: 3 resends, then the pulse.
- Resend and reset: model answers 0xED with 0xFE, then 0xFA -> with `PS2_RETRY_EN` 0xED is resent once; `reset` asserted mid-sequence -> all outputs at reset values next cycle, 0xFF reissued after release.
